set_assoc_dcache: RTL and testbench

- 4-way set-associative, write-back, write-allocate data cache with per-set LRU replacement.
- Sits between a 32-bit load/store requester and a 64-bit-wide backing RAM.
- One cache block is exactly one memory word.
- Reports hit/miss for every completed access.

---
 rtl/dcache_pkg.sv | 15 +
 rtl/dcache_lru_sel.sv | 15 +
 rtl/set_assoc_dcache.sv | 131 +++++++++++++
 tb/tb_set_assoc_dcache.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: address-field widths, cache FSM states and address splitting for set_assoc_dcache
package dcache_pkg;
   localparam int INDEX_W = 10;
   localparam int TAG_W = 19;
   localparam int OFFSET_W = 3;
   typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, INSTALL} state_t;
   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [INDEX_W-1:0] index;
      logic word;
   } fields_t;
   function automatic fields_t addr_fields(input logic [31:2] a);
      return '{tag: a[31:13], index: a[12:3], word: a[2]};
   endfunction
endpackage

// File: rtl/dcache_lru_sel.sv
// dcache_lru_sel: 4-way age update for an accessed way (ages -> next_ages) and age-3 victim pick (victim)
module dcache_lru_sel (
   input  logic [3:0][1:0] ages,
   input  logic [1:0]      way,
   output logic [3:0][1:0] next_ages,
   output logic [1:0]      victim
);
   always_comb begin
      victim = 2'd0;
      for (int i = 0; i < 4; i++) begin
         next_ages[i] = (2'(i) == way) ? 2'd0 : ages[i] + {1'b0, ages[i] < ages[way]};
         if (ages[i] == 2'd3) victim = 2'(i);
      end
   end
endmodule

// File: rtl/set_assoc_dcache.sv
// set_assoc_dcache: 4-way write-back/write-allocate cache; requester side address/din/rden/wren -> q/hit_miss, memory side mrden/mrdaddress/mq fill and mwren/mwraddress/mdout write-back
module set_assoc_dcache
   import dcache_pkg::*;
#(
   parameter int SIZE = 262144,
   parameter int NWAYS = 4,
   parameter int NSETS = 1024,
   parameter int BLOCK_SIZE = 64,
   parameter int WIDTH = 32,
   parameter int MWIDTH = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       address,
   input  logic [WIDTH-1:0]  din,
   input  logic              rden,
   input  logic              wren,
   output logic              hit_miss,
   output logic [WIDTH-1:0]  q,
   output logic [MWIDTH-1:0] mdout,
   output logic [31:0]       mrdaddress,
   output logic              mrden,
   output logic [31:0]       mwraddress,
   output logic              mwren,
   input  logic [MWIDTH-1:0] mq
);
   if (NWAYS != 4 || SIZE != NWAYS * NSETS * BLOCK_SIZE || BLOCK_SIZE != MWIDTH || MWIDTH != 2 * WIDTH)
      begin : g_bad_cfg
         $error("set_assoc_dcache: unsupported geometry");
      end
   localparam int REQ_W = 32 + WIDTH + 2;
   logic [MWIDTH-1:0] mem [NWAYS][NSETS];
   logic [TAG_W-1:0] tags [NWAYS][NSETS];
   logic [1:0] lru [NWAYS][NSETS];
   logic [NSETS-1:0] valid [NWAYS];
   logic [NSETS-1:0] dirty [NWAYS];
   state_t state, next;
   fields_t a, r;
   logic [31:0] req_addr;
   logic [WIDTH-1:0] req_din;
   logic req_rd, req_wr, prev_req, hit, accept;
   logic [REQ_W-1:0] last_req;
   logic [1:0] vic, vic_next, lru_vic, hit_way;
   logic [INDEX_W-1:0] idx;
   logic [NWAYS-1:0] hit_vec;
   logic [3:0][1:0] ages, next_ages;
   function automatic logic [MWIDTH-1:0] merge(input logic [MWIDTH-1:0] b, input logic w, input logic [WIDTH-1:0] d);
      return w ? {d, b[WIDTH-1:0]} : {b[MWIDTH-1:WIDTH], d};
   endfunction
   function automatic logic [WIDTH-1:0] sel(input logic [MWIDTH-1:0] b, input logic w);
      return w ? b[MWIDTH-1:WIDTH] : b[WIDTH-1:0];
   endfunction
   assign a = addr_fields(address[31:2]);
   assign r = addr_fields(req_addr[31:2]);
   assign idx = (state == IDLE) ? a.index : r.index;
   assign hit = |hit_vec;
   assign accept = (state == IDLE) && (rden || wren) && (!prev_req || {address, din, rden, wren} != last_req);
   assign mwren = (state == WRITEBACK);
   assign mrden = (state == FILL);
   assign mwraddress = {tags[vic][r.index], r.index, 3'b000};
   assign mdout = mem[vic][r.index];
   assign mrdaddress = {r.tag, r.index, 3'b000};
   always_comb begin
      hit_way = 2'd0;
      vic_next = lru_vic;
      for (int w = NWAYS - 1; w >= 0; w--) begin
         hit_vec[w] = valid[w][a.index] && tags[w][a.index] == a.tag;
         ages[w] = lru[w][idx];
         if (hit_vec[w]) hit_way = 2'(w);
         if (!valid[w][a.index]) vic_next = 2'(w);
      end
   end
   dcache_lru_sel u_lru (
      .ages(ages),
      .way((state == IDLE) ? hit_way : vic),
      .next_ages(next_ages),
      .victim(lru_vic)
   );
   always_comb begin
      next = state;
      unique case (state)
         IDLE: if (accept && !hit) next = (valid[vic_next][a.index] && dirty[vic_next][a.index]) ? WRITEBACK : FILL;
         WRITEBACK: next = FILL;
         FILL: next = INSTALL;
         default: next = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         q <= '0;
         hit_miss <= 1'b0;
         prev_req <= 1'b0;
         last_req <= '0;
         for (int w = 0; w < NWAYS; w++) begin
            valid[w] <= '0;
            dirty[w] <= '0;
            for (int s = 0; s < NSETS; s++) lru[w][s] <= 2'(w);
         end
      end else begin
         state <= next;
         prev_req <= rden || wren;
         if (accept) begin
            req_addr <= address;
            req_din <= din;
            req_rd <= rden;
            req_wr <= wren;
            vic <= vic_next;
         end
         if (accept && hit) begin
            if (wren) begin
               mem[hit_way][a.index] <= merge(mem[hit_way][a.index], a.word, din);
               dirty[hit_way][a.index] <= 1'b1;
            end else q <= sel(mem[hit_way][a.index], a.word);
            hit_miss <= 1'b1;
            last_req <= {address, din, rden, wren};
         end
         if (state == INSTALL) begin
            mem[vic][r.index] <= req_wr ? merge(mq, r.word, req_din) : mq;
            tags[vic][r.index] <= r.tag;
            valid[vic][r.index] <= 1'b1;
            dirty[vic][r.index] <= req_wr;
            if (!req_wr) q <= sel(mq, r.word);
            hit_miss <= 1'b0;
            last_req <= {req_addr, req_din, req_rd, req_wr};
         end
         if ((accept && hit) || state == INSTALL)
            for (int w = 0; w < NWAYS; w++) lru[w][idx] <= next_ages[w];
      end
   end
endmodule

// File: tb/tb_set_assoc_dcache.sv
// tb_set_assoc_dcache: randomized and directed checks of set_assoc_dcache against a recency-list cache model
module tb_set_assoc_dcache;
   typedef struct packed {
      logic hm;
      logic [31:0] q;
      logic ws;
      logic [31:0] wa;
      logic [63:0] wd;
      logic rs;
      logic [31:0] ra;
   } rec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [31:0] addr = '0, din = '0;
   logic rden = 1'b0, wren = 1'b0;
   logic hit_miss, mrden, mwren;
   logic [31:0] q, mrdaddress, mwraddress;
   logic [63:0] mdout, mq;
   logic [63:0] ram [128];
   logic [63:0] init_ram [128];
   logic ram_loaded = 1'b0;
   int vectors = 0, miscompares = 0;
   logic chk_en = 1'b0;
   rec_t exp_q [$];
   logic [63:0] ref_ram [128];
   logic [63:0] mdata [1024][4];
   logic [18:0] mtag [1024][4];
   logic mval [1024][4];
   logic mdirty [1024][4];
   int order [1024][4];
   logic [31:0] m_q;
   logic m_hit, had_req;
   logic [65:0] last;
   logic [31:0] seen_wa, seen_ra;
   logic [63:0] seen_wd;
   int nwb = 0, nfill = 0;
   always #5 clk = ~clk;
   set_assoc_dcache dut (
      .clock(clk), .reset(rst), .address(addr), .din(din), .rden(rden), .wren(wren),
      .hit_miss(hit_miss), .q(q), .mdout(mdout), .mrdaddress(mrdaddress), .mrden(mrden),
      .mwraddress(mwraddress), .mwren(mwren), .mq(mq)
   );
   always @(posedge clk) begin
      if (!ram_loaded) begin
         for (int i = 0; i < 128; i++) ram[i] <= init_ram[i];
         ram_loaded <= 1'b1;
      end else begin
         if (mwren) ram[mwraddress[9:3]] <= mdout;
         if (mrden) mq <= ram[mrdaddress[9:3]];
      end
   end
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask
   always @(negedge clk) begin
      rec_t e;
      if (mwren) begin seen_wa = mwraddress; seen_wd = mdout; nwb++; end
      if (mrden) begin seen_ra = mrdaddress; nfill++; end
      if (chk_en) begin
         e = '0;
         e.hm = m_hit;
         e.q = m_q;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         chk("hit_miss", 64'(hit_miss), 64'(e.hm));
         chk("q", 64'(q), 64'(e.q));
         chk("mwren", 64'(mwren), 64'(e.ws));
         chk("mrden", 64'(mrden), 64'(e.rs));
         if (e.ws) begin
            chk("mwraddress", 64'(mwraddress), 64'(e.wa));
            chk("mdout", mdout, e.wd);
         end
         if (e.rs) chk("mrdaddress", 64'(mrdaddress), 64'(e.ra));
      end
   end
   task automatic model_reset();
      for (int s = 0; s < 1024; s++)
         for (int w = 0; w < 4; w++) begin
            mval[s][w] = 1'b0;
            mdirty[s][w] = 1'b0;
            order[s][w] = w;
         end
      m_q = '0;
      m_hit = 1'b0;
      last = '0;
      had_req = 1'b0;
   endtask
   task automatic do_op(input int idx, input int w, input logic ws, input logic [31:0] d, input logic wr);
      int p;
      if (wr) begin
         if (ws) mdata[idx][w][63:32] = d;
         else mdata[idx][w][31:0] = d;
         mdirty[idx][w] = 1'b1;
      end else m_q = ws ? mdata[idx][w][63:32] : mdata[idx][w][31:0];
      p = 0;
      for (int i = 0; i < 4; i++) if (order[idx][i] == w) p = i;
      for (int i = p; i > 0; i--) order[idx][i] = order[idx][i-1];
      order[idx][0] = w;
   endtask
   task automatic predict(input logic [31:0] ad, input logic [31:0] d, input logic wr, output int n);
      int idx, w, v;
      logic [18:0] tg;
      logic ws;
      rec_t e;
      idx = int'(ad[12:3]);
      tg = ad[31:13];
      ws = ad[2];
      w = -1;
      for (int i = 0; i < 4; i++) if (mval[idx][i] && mtag[idx][i] == tg) w = i;
      e = '0;
      if (w >= 0) begin
         do_op(idx, w, ws, d, wr);
         m_hit = 1'b1;
         e.hm = 1'b1;
         e.q = m_q;
         exp_q.push_back(e);
         n = 1;
         return;
      end
      n = 3;
      v = order[idx][3];
      for (int i = 3; i >= 0; i--) if (!mval[idx][i]) v = i;
      e.hm = m_hit;
      e.q = m_q;
      if (mval[idx][v] && mdirty[idx][v]) begin
         e.ws = 1'b1;
         e.wa = {mtag[idx][v], 10'(idx), 3'b000};
         e.wd = mdata[idx][v];
         ref_ram[idx % 128] = e.wd;
         exp_q.push_back(e);
         e.ws = 1'b0;
         n = 4;
      end
      e.rs = 1'b1;
      e.ra = {tg, 10'(idx), 3'b000};
      exp_q.push_back(e);
      e.rs = 1'b0;
      exp_q.push_back(e);
      mdata[idx][v] = ref_ram[idx % 128];
      mtag[idx][v] = tg;
      mval[idx][v] = 1'b1;
      mdirty[idx][v] = 1'b0;
      do_op(idx, v, ws, d, wr);
      m_hit = 1'b0;
      e.hm = 1'b0;
      e.q = m_q;
      exp_q.push_back(e);
   endtask
   task automatic access(input logic [31:0] ad, input logic [31:0] d, input logic rd, input logic wr);
      int n;
      logic acc;
      acc = !had_req || {ad, d, rd, wr} != last;
      addr = ad;
      din = d;
      rden = rd;
      wren = wr;
      had_req = 1'b1;
      n = 2;
      if (acc) begin
         predict(ad, d, wr, n);
         last = {ad, d, rd, wr};
      end
      repeat (n) @(negedge clk);
      #1;
   endtask
   task automatic idle();
      rden = 1'b0;
      wren = 1'b0;
      had_req = 1'b0;
      @(negedge clk);
      #1;
   endtask
   initial begin
      logic [31:0] pa, pd;
      logic prd, pwr;
      int nb, nf;
      int sets [4];
      rec_t e;
      sets = '{0, 1, 513, 1023};
      for (int i = 0; i < 128; i++) begin
         init_ram[i] = {$urandom, $urandom};
         if (i == 1) init_ram[i] = 64'h1122334455667788;
         ref_ram[i] = init_ram[i];
      end
      repeat (3) @(negedge clk);
      chk("reset_hit_miss", 64'(hit_miss), 64'd0);
      chk("reset_q", 64'(q), 64'd0);
      chk("reset_mrden", 64'(mrden), 64'd0);
      chk("reset_mwren", 64'(mwren), 64'd0);
      #1;
      rst = 1'b0;
      model_reset();
      chk_en = 1'b1;
      access(32'h0000_0008, 32'h0, 1'b1, 1'b0);
      chk("cold_q", 64'(q), 64'h5566_7788);
      chk("cold_fill_addr", 64'(seen_ra), 64'h8);
      access(32'h0000_0008, 32'hBADD_BEEF, 1'b0, 1'b1);
      chk("store1_hit", 64'(hit_miss), 64'd1);
      access(32'h0000_000B, 32'h0000_0000, 1'b0, 1'b1);
      chk("store2_hit", 64'(hit_miss), 64'd1);
      access(32'h0000_000C, 32'hAAAA_AAAA, 1'b0, 1'b1);
      chk("store3_hit", 64'(hit_miss), 64'd1);
      access(32'h1000_0008, 32'h0, 1'b1, 1'b0);
      access(32'h2000_0008, 32'h0, 1'b1, 1'b0);
      access(32'h3000_0008, 32'h0, 1'b1, 1'b0);
      chk("fill3_miss_q", 64'(q), 64'h5566_7788);
      chk("no_writeback_yet", 64'(nwb), 64'd0);
      access(32'h4000_0008, 32'h0, 1'b1, 1'b0);
      chk("evict_wa", 64'(seen_wa), 64'h8);
      chk("evict_wd", seen_wd, 64'hAAAA_AAAA_0000_0000);
      chk("evict_ram", ram[1], 64'hAAAA_AAAA_0000_0000);
      chk("evict_q", 64'(q), 64'h0);
      access(32'h0000_0008, 32'h0, 1'b1, 1'b0);
      chk("reload_miss", 64'(hit_miss), 64'd0);
      chk("reload_q", 64'(q), 64'h0);
      access(32'h1000_0008, 32'hBADD_BEEF, 1'b0, 1'b1);
      chk("alloc_store_miss", 64'(hit_miss), 64'd0);
      access(32'h1000_0008, 32'h0, 1'b1, 1'b0);
      chk("alloc_load_hit", 64'(hit_miss), 64'd1);
      chk("alloc_load_q", 64'(q), 64'hBADD_BEEF);
      access(32'h1000_000C, 32'h0, 1'b1, 1'b0);
      chk("high_word_q", 64'(q), 64'hAAAA_AAAA);
      nf = nfill;
      nb = nwb;
      access(32'h1000_000C, 32'h0, 1'b1, 1'b0);
      chk("held_no_refill", 64'(nfill), 64'(nf));
      chk("held_no_wb", 64'(nwb), 64'(nb));
      idle();
      for (int k = 0; k < 400; k++) begin
         logic [18:0] tg;
         int op;
         if (k > 0 && $urandom_range(0, 9) == 0) access(pa, pd, prd, pwr);
         else begin
            tg = 19'($urandom_range(0, 5));
            if ($urandom_range(0, 1) == 1) tg[18] = 1'b1;
            op = $urandom_range(0, 3);
            pa = {tg, 10'(sets[$urandom_range(0, 3)]), 1'($urandom), 2'($urandom)};
            pd = $urandom;
            prd = (op != 2);
            pwr = (op >= 2);
            access(pa, pd, prd, pwr);
         end
         if ($urandom_range(0, 1) == 1) idle();
      end
      idle();
      addr = 32'h0000_0018;
      din = '0;
      rden = 1'b1;
      wren = 1'b0;
      e = '0;
      e.hm = m_hit;
      e.q = m_q;
      e.rs = 1'b1;
      e.ra = 32'h0000_0018;
      exp_q.push_back(e);
      @(negedge clk);
      #1;
      chk_en = 1'b0;
      rst = 1'b1;
      rden = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("midreset_hit_miss", 64'(hit_miss), 64'd0);
      chk("midreset_q", 64'(q), 64'd0);
      chk("midreset_mrden", 64'(mrden), 64'd0);
      chk("midreset_mwren", 64'(mwren), 64'd0);
      #1;
      rst = 1'b0;
      model_reset();
      chk_en = 1'b1;
      nf = nfill;
      access(32'h0000_0018, 32'h0, 1'b1, 1'b0);
      chk("post_reset_miss", 64'(hit_miss), 64'd0);
      chk("post_reset_refill", 64'(nfill), 64'(nf + 1));
      idle();
      idle();
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
